// File: rtl/mem_stage_wb_if.sv
// EX/MEM-to-WB handshake bundle for the memory stage: request fields in, branch and WB fields out.
interface mem_stage_wb_if;
   logic [1:0]  MEM_wb;
   logic        MEM_branch;
   logic        MEM_mem_read;
   logic        MEM_mem_write;
   logic [31:0] MEM_branch_target;
   logic        MEM_zero;
   logic [31:0] MEM_alu_result;
   logic [31:0] MEM_reg_data2;
   logic [4:0]  MEM_mux_out;
   logic        pc_src;
   logic [31:0] pc_branch_target;
   logic [1:0]  WB_wb;
   logic [31:0] WB_read_data;
   logic [31:0] WB_alu_result;
   logic [4:0]  WB_mux_out;
   logic        mem_err;

   modport master (
      output MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target,
             MEM_zero, MEM_alu_result, MEM_reg_data2, MEM_mux_out,
      input  pc_src, pc_branch_target, WB_wb, WB_read_data, WB_alu_result,
             WB_mux_out, mem_err
   );

   modport slave (
      input  MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target,
             MEM_zero, MEM_alu_result, MEM_reg_data2, MEM_mux_out,
      output pc_src, pc_branch_target, WB_wb, WB_read_data, WB_alu_result,
             WB_mux_out, mem_err
   );
endinterface

// File: rtl/mem_stage_wb.sv
// Pipeline MEM stage: word-addressed data memory, branch resolution and the MEM/WB register.
module mem_stage_wb #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst_n,
   mem_stage_wb_if.slave bus
);
   localparam int unsigned DW = 32;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] index;
   logic          misaligned;
   logic          wr_en;
   logic          rd_en;

   assign bus.pc_src           = bus.MEM_branch & bus.MEM_zero;
   assign bus.pc_branch_target = bus.MEM_branch_target;

   // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
   assign index      = bus.MEM_alu_result[AW+1:2];
   assign misaligned = (bus.MEM_mem_read | bus.MEM_mem_write) & (|bus.MEM_alu_result[1:0]);
   assign wr_en      = bus.MEM_mem_write & ~misaligned;
   assign rd_en      = bus.MEM_mem_read & ~misaligned;

   // Data memory; cleared by reset so loads after reset return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else if (wr_en) begin
         mem[index] <= bus.MEM_reg_data2;
      end
   end

   // MEM/WB register; a read samples the pre-write word when both hit the same index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.WB_wb         <= '0;
         bus.WB_read_data  <= '0;
         bus.WB_alu_result <= '0;
         bus.WB_mux_out    <= '0;
         bus.mem_err       <= 1'b0;
      end else begin
         bus.WB_wb         <= {bus.MEM_wb[1] & ~misaligned, bus.MEM_wb[0]};
         bus.WB_read_data  <= rd_en ? mem[index] : '0;
         bus.WB_alu_result <= bus.MEM_alu_result;
         bus.WB_mux_out    <= bus.MEM_mux_out;
         if (misaligned) begin
            bus.mem_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed self-checking bench for mem_stage_wb with hand-computed expectations.
module tb_mem_stage_wb;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mem_stage_wb_if bus ();

   mem_stage_wb #(.DEPTH(64), .AW(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] wb, input logic [4:0] rd_num);
      bus.MEM_mem_read  = rd;
      bus.MEM_mem_write = wr;
      bus.MEM_alu_result = addr;
      bus.MEM_reg_data2 = data;
      bus.MEM_wb        = wb;
      bus.MEM_mux_out   = rd_num;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.MEM_branch        = 1'b0;
      bus.MEM_zero          = 1'b0;
      bus.MEM_branch_target = '0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);

      #2;
      chk("reset_wb", 32'(bus.WB_wb), 32'h0);
      chk("reset_rdata", bus.WB_read_data, 32'h0);
      chk("reset_err", 32'(bus.mem_err), 32'h0);
      step();
      step();
      rst_n = 1'b1;

      // Store then load back
      drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
      step();
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd5);
      step();
      chk("load_data", bus.WB_read_data, 32'hDEADBEEF);
      chk("load_wb", 32'(bus.WB_wb), 32'h3);
      chk("load_mux", 32'(bus.WB_mux_out), 32'd5);
      chk("load_alu", bus.WB_alu_result, 32'h10);
      chk("no_err", 32'(bus.mem_err), 32'h0);

      // Branch resolution is combinational
      bus.MEM_branch = 1'b1;
      bus.MEM_zero = 1'b1;
      bus.MEM_branch_target = 32'h20;
      #1;
      chk("br_taken", 32'(bus.pc_src), 32'h1);
      chk("br_target", bus.pc_branch_target, 32'h20);
      bus.MEM_zero = 1'b0;
      #1;
      chk("br_not_taken", 32'(bus.pc_src), 32'h0);
      bus.MEM_branch = 1'b0;

      // Same-cycle read and write: old data first, new data next
      drive(1'b1, 1'b1, 32'h10, 32'hCAFEBABE, 2'b11, 5'd6);
      step();
      chk("rw_old", bus.WB_read_data, 32'hDEADBEEF);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd6);
      step();
      chk("rw_new", bus.WB_read_data, 32'hCAFEBABE);

      // Misaligned store is dropped and flagged
      drive(1'b0, 1'b1, 32'h13, 32'h11111111, 2'b10, 5'd7);
      step();
      chk("mis_wb", 32'(bus.WB_wb), 32'h0);
      chk("mis_err", 32'(bus.mem_err), 32'h1);
      chk("mis_rdata", bus.WB_read_data, 32'h0);
      chk("mis_alu", bus.WB_alu_result, 32'h13);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd7);
      for (int i = 0; i < 10; i++) step();
      chk("mis_mem_kept", bus.WB_read_data, 32'hCAFEBABE);
      chk("mis_wb_aligned", 32'(bus.WB_wb), 32'h3);
      chk("err_sticky", 32'(bus.mem_err), 32'h1);

      // Address wrap modulo 256 bytes
      drive(1'b0, 1'b1, 32'h104, 32'h12345678, 2'b00, 5'd0);
      step();
      drive(1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 5'd1);
      step();
      chk("wrap_data", bus.WB_read_data, 32'h12345678);

      // Pass-through without a memory access
      drive(1'b0, 1'b0, 32'h0F0F0F0F, 32'h0, 2'b01, 5'b11111);
      step();
      chk("pt_alu", bus.WB_alu_result, 32'h0F0F0F0F);
      chk("pt_mux", 32'(bus.WB_mux_out), 32'd31);
      chk("pt_rdata", bus.WB_read_data, 32'h0);
      chk("pt_wb", 32'(bus.WB_wb), 32'h1);

      // Misaligned load returns zero and blocks RegWrite
      drive(1'b1, 1'b0, 32'h12, 32'h0, 2'b11, 5'd2);
      step();
      chk("misrd_data", bus.WB_read_data, 32'h0);
      chk("misrd_wb", 32'(bus.WB_wb), 32'h1);

      // Asynchronous reset between edges, with a store pending across it
      drive(1'b0, 1'b1, 32'h10, 32'h55555555, 2'b11, 5'd9);
      #3;
      rst_n = 1'b0;
      bus.MEM_branch = 1'b1;
      bus.MEM_zero = 1'b1;
      #1;
      chk("arst_wb", 32'(bus.WB_wb), 32'h0);
      chk("arst_rdata", bus.WB_read_data, 32'h0);
      chk("arst_alu", bus.WB_alu_result, 32'h0);
      chk("arst_mux", 32'(bus.WB_mux_out), 32'h0);
      chk("arst_err", 32'(bus.mem_err), 32'h0);
      chk("arst_pc_src", 32'(bus.pc_src), 32'h1);
      step();
      chk("arst_hold_alu", bus.WB_alu_result, 32'h0);
      #3;
      rst_n = 1'b1;
      bus.MEM_branch = 1'b0;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd3);
      step();
      chk("post_rst_0x10", bus.WB_read_data, 32'h0);
      chk("post_rst_wb", 32'(bus.WB_wb), 32'h3);
      drive(1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 5'd3);
      step();
      chk("post_rst_0x4", bus.WB_read_data, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_wb.md
MEM_STAGE_WB -- requirements
Module: mem_stage_wb

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit data-memory words; power of two, 4 to 1024.
REQ-002 Parameter: AW, log2(DEPTH), word-index width.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: MEM_wb  in  2  WB control: [1]=RegWrite, [0]=MemtoReg.
REQ-006 Port: MEM_branch  in  1  branch instruction in MEM.
REQ-007 Port: MEM_mem_read  in  1  load request.
REQ-008 Port: MEM_mem_write  in  1  store request.
REQ-009 Port: MEM_branch_target  in  32  branch target address.
REQ-010 Port: MEM_zero  in  1  ALU zero flag.
REQ-011 Port: MEM_alu_result  in  32  byte address or ALU result.
REQ-012 Port: MEM_reg_data2  in  32  store data.
REQ-013 Port: MEM_mux_out  in  5  destination register number.
REQ-014 Port: pc_src  out  1  take-branch select to the IF stage.
REQ-015 Port: pc_branch_target  out  32  next PC when pc_src=1.
REQ-016 Port: WB_wb  out  2  registered WB control.
REQ-017 Port: WB_read_data  out  32  registered load data.
REQ-018 Port: WB_alu_result  out  32  registered ALU result.
REQ-019 Port: WB_mux_out  out  5  registered destination register.
REQ-020 Port: mem_err  out  1  sticky misaligned-access flag.

Function
REQ-021 pc_src SHALL be combinational: MEM_branch AND MEM_zero.
REQ-022 pc_branch_target SHALL be combinational and equal to MEM_branch_target.
REQ-023 Word index SHALL be MEM_alu_result[AW+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-024 An access is misaligned when MEM_alu_result[1:0] != 0 while MEM_mem_read or MEM_mem_write is 1.
REQ-025 On a rising edge with MEM_mem_write=1 and the access aligned, mem[index] SHALL take MEM_reg_data2.
REQ-026 A misaligned store SHALL NOT modify memory.
REQ-027 Every rising edge SHALL register the EX/MEM pass-through fields: WB_wb<=MEM_wb, WB_alu_result<=MEM_alu_result, WB_mux_out<=MEM_mux_out.
REQ-028 WB_read_data SHALL take mem[index] on a rising edge when MEM_mem_read=1 and the access is aligned.
REQ-029 A read in the same cycle as a write to the same index SHALL return the pre-write contents; the new value is visible from the next cycle.
REQ-030 WB_read_data SHALL take 0 when MEM_mem_read=0 or the access is misaligned.
REQ-031 On a misaligned access, WB_wb[1] SHALL be cleared so no register write occurs; the other fields pass unchanged.
REQ-032 mem_err SHALL be set on the edge that captures a misaligned access and SHALL hold until reset.
REQ-033 Latency: inputs SHALL appear on WB_* one clock edge later; pc_src and pc_branch_target have zero latency.
REQ-034 MEM_mem_read and MEM_mem_write both 1 SHALL perform both operations, per REQ-029.

Reset
REQ-035 While rst_n=0, regardless of clk, WB_wb=0, WB_read_data=0, WB_alu_result=0, WB_mux_out=0, mem_err=0, and every memory word SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard any store on that edge; the first capture after release SHALL occur on the first rising edge with rst_n=1.
REQ-037 pc_src SHALL follow its inputs during reset, because it is combinational.

Verification
REQ-038 Reset then store: MEM_mem_write=1, alu_result=0x10, reg_data2=0xDEADBEEF; next cycle load from 0x10 with MEM_wb=2'b11 -> WB_read_data=0xDEADBEEF, WB_wb=2'b11.
REQ-039 Branch: MEM_branch=1, MEM_zero=1, target=0x20 -> pc_src=1 and pc_branch_target=0x20 in the same cycle; with MEM_zero=0 -> pc_src=0.
REQ-040 Same-cycle read and write to 0x10 (holding 0xDEADBEEF), writing 0xCAFEBABE -> WB_read_data=0xDEADBEEF; next-cycle read -> 0xCAFEBABE.
REQ-041 Misaligned store to 0x13 with MEM_wb=2'b10 -> memory unchanged, WB_wb=2'b00, mem_err=1 and still 1 after ten further aligned cycles.
REQ-042 Wrap: with DEPTH=64, store 0x12345678 at 0x104 -> a load from 0x4 returns 0x12345678.
REQ-043 Pass-through: alu_result=0x0F0F0F0F, mux_out=5'b11111, mem_read=0 -> WB_alu_result=0x0F0F0F0F, WB_mux_out=31, WB_read_data=0.
REQ-044 Assert rst_n=0 between clock edges -> all WB_* outputs and mem_err go to 0 immediately, and a read of 0x10 after release returns 0.
